// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame-state type for the PS/2 scan receiver
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } frame_state_e;

endpackage

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 pin synchronizer, frame FSM, parity/stop check and timeout
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]        LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    frame_state_e     state;
    frame_state_e     state_next;
    logic [3:0]       bit_cnt;
    logic [8:0]       shreg;
    logic [CNT_W-1:0] to_cnt;
    logic             frame_last;
    logic             timed_out;
    logic             frame_good;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Lines idle high, so synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_last = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: if (fall && !data_s) state_next = RECV;
            RECV: begin
                if (fall) begin
                    if (bit_cnt == LAST_BIT) begin
                        frame_last = 1'b1;
                        state_next = IDLE;
                    end
                end else if (to_cnt == TO_LAST) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // shreg holds {parity, d7..d0} once the stop bit arrives; odd parity over all nine.
    assign frame_good = data_s & (^shreg);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            to_cnt      <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;

            if (fall || state != RECV) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (state == IDLE && fall && !data_s) begin
                bit_cnt <= 4'd1;
            end else if (frame_last) begin
                bit_cnt     <= '0;
                byte_valid  <= frame_good;
                frame_error <= ~frame_good;
                if (frame_good) rx_byte <= shreg[7:0];
            end else if (state == RECV && fall) begin
                shreg   <= {data_s, shreg[8:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (timed_out) begin
                bit_cnt     <= '0;
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard receiver folding F0/E0 prefixes into scan-code events
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       scan_break,
    output logic       scan_ext,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       brk_pend;
    logic       ext_pend;

    ps2_frame_receiver #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clock       (clock),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .frame_error (frame_error)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scan_code  <= '0;
            scan_valid <= 1'b0;
            scan_break <= 1'b0;
            scan_ext   <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            if (frame_error) begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == PS2_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
                    // keyboard overrun: any pending prefix belonged to a lost code
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end else begin
                    scan_valid <= 1'b1;
                    scan_code  <= rx_byte;
                    scan_break <= brk_pend;
                    scan_ext   <= ext_pend;
                    brk_pend   <= 1'b0;
                    ext_pend   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - scoreboard testbench for ps2_scan_receiver
module tb_ps2_scan_receiver;

    localparam int S    = 2;
    localparam int T    = 300;
    localparam int HALF = 25;
    localparam int GAP  = 400;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_break;
    logic       scan_ext;
    logic       frame_error;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_fall_cyc = 0;
    int  err_cyc = -1;

    ps2_scan_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .scan_break  (scan_break),
        .scan_ext    (scan_ext),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_code(input logic [7:0] c, input bit b, input bit e);
        ev_t ev;
        ev.is_err = 1'b0; ev.code = c; ev.brk = b; ev.ext = e;
        exp_q.push_back(ev);
    endfunction

    function automatic void expect_err();
        ev_t ev;
        ev.is_err = 1'b1; ev.code = 8'h00; ev.brk = 1'b0; ev.ext = 1'b0;
        exp_q.push_back(ev);
    endfunction

    always @(negedge clock) begin
        if (reset_n && (scan_valid || frame_error)) begin
            chk("valid_error_exclusive", 32'(scan_valid & frame_error), 32'd0);
            if (frame_error) err_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0h, required no event",
                         scan_valid, frame_error, scan_code);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                chk("event_is_error", 32'(frame_error), 32'(ev.is_err));
                if (!ev.is_err && scan_valid) begin
                    chk("scan_code", 32'(scan_code), 32'(ev.code));
                    chk("scan_break", 32'(scan_break), 32'(ev.brk));
                    chk("scan_ext", 32'(scan_ext), 32'(ev.ext));
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clock);
    endtask

    initial begin
        repeat (4) @(negedge clock);
        chk("reset_scan_code", 32'(scan_code), 32'h00);
        chk("reset_scan_valid", 32'(scan_valid), 32'd0);
        chk("reset_scan_break", 32'(scan_break), 32'd0);
        chk("reset_scan_ext", 32'(scan_ext), 32'd0);
        chk("reset_frame_error", 32'(frame_error), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        expect_code(8'h1C, 0, 0); send_frame(8'h1C, 0, 11);
        send_frame(8'hF0, 0, 11);
        expect_code(8'h1C, 1, 0); send_frame(8'h1C, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        expect_code(8'h75, 1, 1); send_frame(8'h75, 0, 11);

        expect_err(); send_frame(8'h1C, 1, 11);
        expect_code(8'h32, 0, 0); send_frame(8'h32, 0, 11);

        // overrun byte drops a pending extended prefix
        send_frame(8'hE0, 0, 11);
        send_frame(8'h00, 0, 11);
        expect_code(8'h5A, 0, 0); send_frame(8'h5A, 0, 11);

        // bad parity after F0 clears the break flag
        send_frame(8'hF0, 0, 11);
        expect_err(); send_frame(8'h12, 1, 11);
        expect_code(8'h12, 0, 0); send_frame(8'h12, 0, 11);

        err_cyc = -1;
        expect_err(); send_frame(8'h3C, 0, 5);
        chk("timeout_latency", 32'(err_cyc - last_fall_cyc), 32'(S + 1 + T));
        expect_code(8'h24, 0, 0); send_frame(8'h24, 0, 11);

        send_frame(8'hF0, 0, 11);
        for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (T + 100) @(negedge clock);
        expect_code(8'h1B, 0, 0); send_frame(8'h1B, 0, 11);

        repeat (50) @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
